// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: shares the single-port data memory between the CPU M stage
// (port C) and a DMA/debug loader (port D). C has fixed priority, and a
// starvation counter forces D ahead once it has been denied STARVE_LIMIT
// cycles in a row. Read data returns one cycle after grant, tagged to the
// port that won. Out-of-range reads return BADREAD; out-of-range writes are
// dropped.
// Optional feature: define DMEM_ARB_STATS_EN to add per-port grant counters
// (c_cnt, d_cnt) and the longest observed D wait (max_wait).
module dmem_bus_arbiter #(
    parameter int                 DBITS        = 32,
    parameter int                 DMEMADDRBITS = 16,
    parameter int                 DMEMWORDBITS = 2,
    parameter int                 STARVE_LIMIT = 4,
    parameter logic [DBITS-1:0]   BADREAD      = 32'hDEADDEAD
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 c_req,
    input  logic                                 c_we,
    input  logic [DBITS-1:0]                     c_addr,
    input  logic [DBITS-1:0]                     c_wdata,
    output logic                                 c_gnt,
    output logic                                 c_rvalid,
    output logic [DBITS-1:0]                     c_rdata,
    input  logic                                 d_req,
    input  logic                                 d_we,
    input  logic [DBITS-1:0]                     d_addr,
    input  logic [DBITS-1:0]                     d_wdata,
    output logic                                 d_gnt,
    output logic                                 d_rvalid,
    output logic [DBITS-1:0]                     d_rdata,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_widx,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata,
    output logic                                 cpu_stall
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]                          c_cnt,
    output logic [31:0]                          d_cnt,
    output logic [7:0]                           max_wait
`endif
);

    // Counter just wide enough to hold STARVE_LIMIT (at least one bit).
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0]    starve_cnt_reg;
    logic             rpend_reg;
    logic             rsel_reg;     // 0 = C, 1 = D
    logic             rbad_reg;

    logic             d_force;
    logic             any_gnt;
    logic             sel_we;
    logic [DBITS-1:0] sel_addr;
    logic             in_range;
    logic [DBITS-1:0] rdata_ret;
    logic             unused_bits;

    // Arbitration, winner mux and address decode; everything is gated off in reset.
    always_comb begin
        d_force   = d_req && (starve_cnt_reg >= LIMIT);
        d_gnt     = 1'b0;
        c_gnt     = 1'b0;
        cpu_stall = 1'b0;
        if (!reset) begin
            d_gnt     = d_req && (!c_req || d_force);
            c_gnt     = c_req && !d_gnt;
            cpu_stall = c_req && !c_gnt;
        end
        any_gnt   = c_gnt || d_gnt;
        sel_we    = d_gnt ? d_we    : c_we;
        sel_addr  = d_gnt ? d_addr  : c_addr;
        mem_wdata = d_gnt ? d_wdata : c_wdata;
        in_range  = (sel_addr[DBITS-1:DMEMADDRBITS] == '0);
        mem_en    = any_gnt && in_range;
        mem_we    = mem_en && sel_we;
        mem_widx  = sel_addr[DMEMADDRBITS-1:DMEMWORDBITS];
    end

    // Byte-offset bits are ignored: the memory is word addressed.
    assign unused_bits = ^sel_addr[DMEMWORDBITS-1:0];

    // Starvation counter: counts consecutive denied D cycles, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (!d_req || d_gnt) begin
            starve_cnt_reg <= '0;
        end else if (starve_cnt_reg < LIMIT) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    // Read tracking: remember which port owns the data arriving next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpend_reg <= 1'b0;
            rsel_reg  <= 1'b0;
            rbad_reg  <= 1'b0;
        end else begin
            rpend_reg <= any_gnt && !sel_we;
            rsel_reg  <= d_gnt;
            rbad_reg  <= !in_range;
        end
    end

    assign rdata_ret = rbad_reg ? BADREAD : mem_rdata;

    // Per-port return channel: index 0 is C, index 1 is D.
    logic [1:0]       rvalid_vec;
    logic [DBITS-1:0] rdata_vec [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            logic [DBITS-1:0] hold_reg;

            assign rvalid_vec[gi] = rpend_reg && (rsel_reg == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? rdata_ret : hold_reg;

            // Keep the last delivered word so rdata is stable between returns.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_reg <= '0;
                end else if (rvalid_vec[gi]) begin
                    hold_reg <= rdata_ret;
                end
            end
        end
    endgenerate

    assign c_rvalid = rvalid_vec[0];
    assign d_rvalid = rvalid_vec[1];
    assign c_rdata  = rdata_vec[0];
    assign d_rdata  = rdata_vec[1];

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] c_cnt_reg;
    logic [31:0] d_cnt_reg;
    logic [7:0]  wait_cnt_reg;
    logic [7:0]  max_wait_reg;

    // Grant counters wrap; D wait length saturates and is folded into the max at each D grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_cnt_reg    <= '0;
            d_cnt_reg    <= '0;
            wait_cnt_reg <= '0;
            max_wait_reg <= '0;
        end else begin
            if (c_gnt) begin
                c_cnt_reg <= c_cnt_reg + 32'd1;
            end
            if (d_gnt) begin
                d_cnt_reg <= d_cnt_reg + 32'd1;
                if (wait_cnt_reg > max_wait_reg) begin
                    max_wait_reg <= wait_cnt_reg;
                end
            end
            if (!d_req || d_gnt) begin
                wait_cnt_reg <= '0;
            end else if (wait_cnt_reg != 8'hFF) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
        end
    end

    assign c_cnt    = c_cnt_reg;
    assign d_cnt    = d_cnt_reg;
    assign max_wait = max_wait_reg;
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single-port data memory (16-bit byte address space, word-addressed) between two requesters.
  - Port C: the CPU M stage.
  - Port D: a DMA/debug loader that preloads or inspects dmem while the core runs.
- Fixed priority to C, with a starvation counter that guarantees D forward progress.
- Returns read data one cycle after grant, tagged to the winning port.
- Sits between the M-stage memory signals and the dmem array. The CPU stalls on lost arbitration.

Parameters:
- DBITS, 32, data/address width.
- DMEMADDRBITS, 16, byte-address bits decoded as memory.
- DMEMWORDBITS, 2, byte-offset bits dropped to form the word index.
- STARVE_LIMIT, 4, consecutive denied D cycles before D is forced ahead of C (0 = D always wins).
- BADREAD, 32'hDEADDEAD, read data returned for out-of-range addresses.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- c_req  in  1  CPU access request
- c_we  in  1  CPU write enable (1 = write)
- c_addr  in  DBITS  CPU byte address
- c_wdata  in  DBITS  CPU write data
- c_gnt  out  1  CPU granted this cycle
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  DBITS  CPU read data
- d_req, d_we, d_addr, d_wdata  in  1/1/DBITS/DBITS  DMA request, same meaning as the C signals
- d_gnt, d_rvalid, d_rdata  out  1/1/DBITS  DMA grant, read valid, read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_widx  out  DMEMADDRBITS-DMEMWORDBITS  word index
- mem_wdata  out  DBITS  memory write data
- mem_rdata  in  DBITS  memory read data; synchronous, valid the cycle after mem_en
- cpu_stall  out  1  c_req & ~c_gnt

Behaviour:
- Reset (async, active-high):
  - starve_cnt=0, rsel=0, rpend=0, rbad=0.
  - c_rvalid=d_rvalid=0, c_rdata=d_rdata=0.
  - While reset is high: c_gnt, d_gnt, mem_en, mem_we and cpu_stall are forced to 0.
- Grants are combinational in the request cycle. A transfer occurs at the posedge where req&gnt=1.
  - A requester holds req/we/addr/wdata stable until granted.
  - At most one grant per cycle.
- Arbitration:
  - d_force = d_req & (starve_cnt >= STARVE_LIMIT).
  - d_gnt = d_req & (~c_req | d_force).
  - c_gnt = c_req & ~d_gnt.
- Starvation counter:
  - Increments by 1 each cycle d_req&~d_gnt, saturating at STARVE_LIMIT.
  - Cleared to 0 on any d_gnt, or when d_req=0.
- Address decode:
  - in_range = (addr[DBITS-1:DMEMADDRBITS]==0) for the granted port.
  - mem_en = gnt & in_range.
  - mem_we = mem_en & we.
  - mem_widx = addr[DMEMADDRBITS-1:DMEMWORDBITS].
  - mem_wdata = winning port's wdata.
- Out-of-range access: still granted. Write is dropped (mem_en=0). Read returns BADREAD.
- Read return, one-cycle latency:
  - On a granted read, register rpend=1, rsel=winner, rbad=~in_range.
  - Next cycle: the selected x_rvalid=1 and x_rdata = rbad ? BADREAD : mem_rdata. The other port's rvalid=0.
  - x_rdata holds its last value when rvalid=0.
- Granted writes produce no rvalid.
- Back-to-back reads by either port every cycle are supported at full throughput.
- Simultaneous c_req&d_req with starve_cnt<STARVE_LIMIT: C wins. At the limit: D wins for exactly one grant, then the counter clears.
- Reset asserted while a read is pending: the rvalid is killed and not delivered after reset release.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds outputs c_cnt and d_cnt (32 bits each) and max_wait (8 bits):
  - c_cnt, d_cnt: count granted transfers per port.
  - max_wait: largest observed D wait in cycles, saturating at 255.
  - All three reset to 0 and wrap naturally (max_wait saturates).
- When undefined, these ports and their registers do not exist and behaviour is otherwise identical.

Test Plan:
- C read of 0x00000100 alone, mem_rdata=0x12345678 → c_gnt=1 same cycle, mem_widx=0x40, next cycle c_rvalid=1 with c_rdata=0x12345678, d_rvalid=0.
- c_req and d_req held high continuously, STARVE_LIMIT=4 → C granted 4 cycles, D granted on the 5th, repeating with period 5; cpu_stall=1 only on D cycles.
- D write to 0xFFFFF000 → d_gnt=1, mem_en=0. D read of 0x00010000 → d_rvalid next cycle with d_rdata=0xDEADDEAD.
- C write 0x00000200=0xCAFEF00D followed by D read of 0x200 → mem_we=1 at idx 0x80, then d_rdata=0xCAFEF00D one cycle after d_gnt.
- Granted read, reset pulsed before the next posedge → no rvalid; all outputs 0 during reset; starve_cnt back to 0 (D loses to C for the next 4 cycles).
- With DMEM_ARB_STATS_EN: run the contention test for 20 cycles → c_cnt=16, d_cnt=4, max_wait=4.
